// File: rtl/sdram_p2_arbiter.sv
// Round-robin arbiter sharing SDRAM controller port 2 among three clients.
// Turns level requests into a single-cycle mem_req pulse and aborts stalled transfers.
module sdram_p2_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_req,
  input  logic        c0_wren,
  input  logic [19:0] c0_addr,
  input  logic [63:0] c0_wdata,
  output logic        c0_ack,
  output logic        c0_err,
  input  logic        c1_req,
  input  logic        c1_wren,
  input  logic [19:0] c1_addr,
  input  logic [63:0] c1_wdata,
  output logic        c1_ack,
  output logic        c1_err,
  input  logic        c2_req,
  input  logic        c2_wren,
  input  logic [19:0] c2_addr,
  input  logic [63:0] c2_wdata,
  output logic        c2_ack,
  output logic        c2_err,
  output logic [63:0] c_rdata,
  output logic [12:0] mem_address,
  output logic [6:0]  mem_page,
  output logic [63:0] mem_to_mem,
  output logic        mem_wren,
  output logic        mem_req,
  input  logic [63:0] mem_from_mem,
  input  logic        mem_ready,
  output logic        timeout_flag
);

  // state | meaning
  // IDLE  | pick next requester round-robin, capture its command
  // ISSUE | one-cycle mem_req pulse, arm watchdog
  // WAIT  | wait for mem_ready or watchdog expiry
  // DONE  | ack (and err) to the granted client
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [15:0] WD_LOAD = 16'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [1:0]  last_grant, grant, pick, p0, p1;
  logic [3:0]  req_vec;
  logic        hit, err_q;
  logic [15:0] wd;
  logic [19:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        sel_wren;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign req_vec = {1'b0, c2_req, c1_req, c0_req};
  assign p0      = inc3(last_grant);
  assign p1      = inc3(p0);

  // Highest priority is checked last so it overrides the others.
  always_comb begin
    hit  = |req_vec;
    pick = last_grant;
    if (req_vec[last_grant]) pick = last_grant;
    if (req_vec[p1])         pick = p1;
    if (req_vec[p0])         pick = p0;
  end

  always_comb begin
    sel_addr  = c0_addr;
    sel_wdata = c0_wdata;
    sel_wren  = c0_wren;
    case (pick)
      2'd1: begin
        sel_addr  = c1_addr;
        sel_wdata = c1_wdata;
        sel_wren  = c1_wren;
      end
      2'd2: begin
        sel_addr  = c2_addr;
        sel_wdata = c2_wdata;
        sel_wren  = c2_wren;
      end
      default: ;
    endcase
  end

  // The watchdog holds the cycles remaining including the current one,
  // so it expires on the WAIT cycle where it would decrement to zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_ready || wd == 16'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 2'd2;
      grant        <= 2'd0;
      err_q        <= 1'b0;
      wd           <= 16'd0;
      timeout_flag <= 1'b0;
      mem_address  <= 13'd0;
      mem_page     <= 7'd0;
      mem_to_mem   <= 64'd0;
      mem_wren     <= 1'b0;
      c_rdata      <= 64'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (hit) begin
            grant       <= pick;
            mem_address <= sel_addr[12:0];
            mem_page    <= sel_addr[19:13];
            mem_to_mem  <= sel_wdata;
            mem_wren    <= sel_wren;
          end
        end
        ISSUE: wd <= WD_LOAD;
        WAIT: begin
          wd <= wd - 16'd1;
          if (mem_ready) begin
            err_q <= 1'b0;
            if (!mem_wren) c_rdata <= mem_from_mem;
          end else if (wd == 16'd1) begin
            err_q        <= 1'b1;
            timeout_flag <= 1'b1;
          end
        end
        DONE: last_grant <= grant;
        default: ;
      endcase
    end
  end

  assign mem_req = (state == ISSUE);
  assign c0_ack  = (state == DONE) && (grant == 2'd0);
  assign c1_ack  = (state == DONE) && (grant == 2'd1);
  assign c2_ack  = (state == DONE) && (grant == 2'd2);
  assign c0_err  = c0_ack && err_q;
  assign c1_err  = c1_ack && err_q;
  assign c2_err  = c2_ack && err_q;

endmodule

// File: tb/tb_sdram_p2_arbiter.sv
// Directed self-checking bench for sdram_p2_arbiter (TIMEOUT_CYCLES=16).
module tb_sdram_p2_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req, c0_wren, c1_req, c1_wren, c2_req, c2_wren;
  logic [19:0] c0_addr, c1_addr, c2_addr;
  logic [63:0] c0_wdata, c1_wdata, c2_wdata;
  logic        c0_ack, c0_err, c1_ack, c1_err, c2_ack, c2_err;
  logic [63:0] c_rdata, mem_to_mem, mem_from_mem;
  logic [12:0] mem_address;
  logic [6:0]  mem_page;
  logic        mem_wren, mem_req, mem_ready, timeout_flag;

  int tests = 0;
  int fails = 0;
  int req_cnt = 0;
  int ack_cnt = 0;

  sdram_p2_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_wren(c0_wren), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_err(c0_err),
    .c1_req(c1_req), .c1_wren(c1_wren), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_err(c1_err),
    .c2_req(c2_req), .c2_wren(c2_wren), .c2_addr(c2_addr), .c2_wdata(c2_wdata),
    .c2_ack(c2_ack), .c2_err(c2_err),
    .c_rdata(c_rdata), .mem_address(mem_address), .mem_page(mem_page),
    .mem_to_mem(mem_to_mem), .mem_wren(mem_wren), .mem_req(mem_req),
    .mem_from_mem(mem_from_mem), .mem_ready(mem_ready), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_cnt <= req_cnt + int'(mem_req);
    ack_cnt <= ack_cnt + int'(c0_ack) + int'(c1_ack) + int'(c2_ack);
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_mem_req(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!mem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    ok = mem_req;
  endtask

  task automatic test_reset;
    do_reset();
    tests++;
    if ({mem_req, mem_wren, c0_ack, c1_ack, c2_ack, c0_err, c1_err, c2_err, timeout_flag} !== 9'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0", {mem_req, mem_wren, c0_ack, c1_ack, c2_ack, timeout_flag});
    end
    tests++;
    if ({mem_address, mem_page, mem_to_mem, c_rdata} !== 148'd0) begin
      fails++;
      $display("FAIL reset_data: got addr %h page %h to_mem %h rdata %h required 0",
               mem_address, mem_page, mem_to_mem, c_rdata);
    end
  endtask

  task automatic test_single_read;
    bit ok;
    bit early = 1'b0;
    c1_addr = 20'h12345; c1_wren = 1'b0; c1_req = 1'b1;
    mem_from_mem = 64'hDEADBEEF_01234567;
    wait_mem_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL read_req_timeout: got no mem_req required pulse"); end
    tests++;
    if (mem_page !== 7'h09 || mem_address !== 13'h0345 || mem_wren !== 1'b0) begin
      fails++;
      $display("FAIL read_cmd: got page %h addr %h wren %b required 09 0345 0", mem_page, mem_address, mem_wren);
    end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      mem_ready = (n == 9);
      if (n < 10 && (c0_ack || c1_ack || c2_ack)) early = 1'b1;
    end
    tests++;
    if (early) begin fails++; $display("FAIL read_early_ack: got ack before 10 cycles required none"); end
    tests++;
    if (c1_ack !== 1'b1 || c1_err !== 1'b0 || c_rdata !== 64'hDEADBEEF_01234567) begin
      fails++;
      $display("FAIL read_ack: got ack %b err %b rdata %h required 1 0 deadbeef01234567", c1_ack, c1_err, c_rdata);
    end
    c1_req = 1'b0;
  endtask

  task automatic test_write;
    bit ok;
    int r0;
    r0 = req_cnt;
    c2_addr = 20'h00003; c2_wren = 1'b1; c2_wdata = 64'hA5A5A5A5_A5A5A5A5; c2_req = 1'b1;
    mem_from_mem = 64'h1111_2222_3333_4444;
    wait_mem_req(ok);
    tests++;
    if (!ok || mem_wren !== 1'b1 || mem_to_mem !== 64'hA5A5A5A5_A5A5A5A5 || mem_address !== 13'h3 || mem_page !== 7'h0) begin
      fails++;
      $display("FAIL write_cmd: got req %b wren %b to_mem %h addr %h page %h required 1 1 a5a5a5a5a5a5a5a5 0003 00",
               ok, mem_wren, mem_to_mem, mem_address, mem_page);
    end
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    tests++;
    if (c2_ack !== 1'b1 || c2_err !== 1'b0 || c_rdata !== 64'hDEADBEEF_01234567) begin
      fails++;
      $display("FAIL write_ack: got ack %b err %b rdata %h required 1 0 deadbeef01234567", c2_ack, c2_err, c_rdata);
    end
    c2_req = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (req_cnt - r0 !== 1) begin fails++; $display("FAIL write_req_count: got %0d required 1", req_cnt - r0); end
  endtask

  task automatic test_round_robin;
    bit ok;
    int r0, a0;
    logic [2:0]  exp_ack;
    logic [12:0] exp_addr;
    do_reset();
    r0 = req_cnt; a0 = ack_cnt;
    c0_addr = 20'h00010; c1_addr = 20'h00020; c2_addr = 20'h00030;
    c0_wren = 1'b0; c1_wren = 1'b0; c2_wren = 1'b0;
    c0_req = 1'b1; c1_req = 1'b1; c2_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_ack  = 3'b001 << (i % 3);
      exp_addr = 13'h10 * 13'((i % 3) + 1);
      wait_mem_req(ok);
      tests++;
      if (!ok || mem_address !== exp_addr) begin
        fails++;
        $display("FAIL rr_issue%0d: got req %b addr %h required 1 %h", i, ok, mem_address, exp_addr);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      mem_from_mem = 64'(i);
      @(negedge clk);
      mem_ready = 1'b0;
      tests++;
      if ({c2_ack, c1_ack, c0_ack} !== exp_ack) begin
        fails++;
        $display("FAIL rr_grant%0d: got %b required %b", i, {c2_ack, c1_ack, c0_ack}, exp_ack);
      end
    end
    c0_req = 1'b0; c1_req = 1'b0; c2_req = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (req_cnt - r0 !== 6 || ack_cnt - a0 !== 6) begin
      fails++;
      $display("FAIL rr_counts: got req %0d ack %0d required 6 6", req_cnt - r0, ack_cnt - a0);
    end
  endtask

  task automatic test_collision;
    bit ok;
    bit early = 1'b0;
    c0_addr = 20'h00100; c0_wren = 1'b0; c0_req = 1'b1;
    mem_from_mem = 64'hC011_1510_0000_0001;
    wait_mem_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL coll_req_timeout: got no mem_req required pulse"); end
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      mem_ready = (n == 16);
      if (n < 17 && (c0_ack || c1_ack || c2_ack)) early = 1'b1;
    end
    tests++;
    if (early || c0_ack !== 1'b1 || c0_err !== 1'b0 || timeout_flag !== 1'b0 || c_rdata !== 64'hC011_1510_0000_0001) begin
      fails++;
      $display("FAIL collision: got early %b ack %b err %b flag %b rdata %h required 0 1 0 0 c011151000000001",
               early, c0_ack, c0_err, timeout_flag, c_rdata);
    end
    c0_req = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    bit early = 1'b0;
    bit late = 1'b0;
    c0_req = 1'b1;
    mem_from_mem = 64'hBAD0_BAD0_BAD0_BAD0;
    wait_mem_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL to_req_timeout: got no mem_req required pulse"); end
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n < 17 && (c0_ack || c1_ack || c2_ack)) early = 1'b1;
    end
    tests++;
    if (early || c0_ack !== 1'b1 || c0_err !== 1'b1 || timeout_flag !== 1'b1) begin
      fails++;
      $display("FAIL timeout_ack: got early %b ack %b err %b flag %b required 0 1 1 1", early, c0_ack, c0_err, timeout_flag);
    end
    c0_req = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (c0_ack || c1_ack || c2_ack || mem_req) late = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (late || timeout_flag !== 1'b1 || c_rdata !== 64'hC011_1510_0000_0001) begin
      fails++;
      $display("FAIL late_ready: got activity %b flag %b rdata %h required 0 1 c011151000000001", late, timeout_flag, c_rdata);
    end
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    int a0;
    a0 = ack_cnt;
    c1_addr = 20'h7FFFF; c1_wren = 1'b0; c1_req = 1'b1;
    mem_from_mem = 64'h0123_4567_89AB_CDEF;
    wait_mem_req(ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (!ok || ack_cnt != a0 || {c0_ack, c1_ack, c2_ack, mem_req, mem_wren, timeout_flag} !== 6'd0 ||
        {mem_address, mem_page, mem_to_mem, c_rdata} !== 148'd0) begin
      fails++;
      $display("FAIL reset_mid_wait: got acks %0d flag %b addr %h page %h rdata %h required 0 0 0 0 0",
               ack_cnt - a0, timeout_flag, mem_address, mem_page, c_rdata);
    end
    wait_mem_req(ok);
    tests++;
    if (!ok || mem_page !== 7'h3F || mem_address !== 13'h1FFF) begin
      fails++;
      $display("FAIL post_reset_cmd: got req %b page %h addr %h required 1 3f 1fff", ok, mem_page, mem_address);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    tests++;
    if (c1_ack !== 1'b1 || c1_err !== 1'b0 || c_rdata !== 64'h0123_4567_89AB_CDEF) begin
      fails++;
      $display("FAIL post_reset_ack: got ack %b err %b rdata %h required 1 0 0123456789abcdef", c1_ack, c1_err, c_rdata);
    end
    c1_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    {c0_req, c0_wren, c1_req, c1_wren, c2_req, c2_wren} = '0;
    c0_addr = '0; c1_addr = '0; c2_addr = '0;
    c0_wdata = '0; c1_wdata = '0; c2_wdata = '0;
    mem_from_mem = '0; mem_ready = 1'b0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_collision();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running required finish");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/sdram_p2_arbiter.md
# sdram_p2_arbiter

Three-client round-robin arbiter that shares the SDRAM controller's 64-bit read/write port (port 2) among independent requesters such as the programmer command engine, the verify engine and the host bridge. It converts each client's level-held request into the single-cycle, edge-detected request pulse the controller expects. It captures the controller's one-cycle ready pulse and routes read data and a completion acknowledge back to the granted client. A watchdog aborts transactions the controller never completes.

## Interface
- TIMEOUT_CYCLES, 1023: maximum cycles waited for mem_ready after the request pulse before the transaction is aborted. Range 16..65535.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cN_req  in  1  (N=0,1,2) client request; level, held until cN_ack.
- cN_wren  in  1  1=write, 0=read; stable while cN_req.
- cN_addr  in  20  64-bit word address {page[6:0], address[12:0]}; stable while cN_req.
- cN_wdata  in  64  write data; stable while cN_req.
- cN_ack  out  1  one-cycle completion pulse to client N.
- cN_err  out  1  qualifies cN_ack; 1 = transaction aborted by the watchdog.
- c_rdata  out  64  shared read-data register.
- mem_address  out  13  to controller p2_address = captured addr[12:0].
- mem_page  out  7  to controller p2_page = captured addr[19:13].
- mem_to_mem  out  64  to controller p2_to_mem.
- mem_wren  out  1  to controller p2_wren.
- mem_req  out  1  to controller p2_req; single-cycle pulse.
- mem_from_mem  in  64  controller p2_from_mem.
- mem_ready  in  1  controller p2_ready; one-cycle pulse at completion.
- timeout_flag  out  1  sticky; set on any abort, cleared only by rst.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: evaluate requests in round-robin order starting at (last_grant+1) mod 3. On a hit, record the grant, capture cN_addr, cN_wdata and cN_wren into the mem_* registers, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: mem_req=1 for exactly this cycle. Load the watchdog with TIMEOUT_CYCLES. Go to WAIT.
- WAIT: mem_req=0. The watchdog decrements each cycle.
  - If mem_ready=1: when the captured wren=0, load c_rdata <= mem_from_mem; then go to DONE with err=0.
  - Else if watchdog==0: set timeout_flag and go to DONE with err=1. c_rdata is unchanged.
  - mem_ready has priority over expiry in the same cycle.
- DONE: the granted client's cN_ack=1 and cN_err=err. last_grant <= granted index. Go to IDLE.
- A client that still holds cN_req in the cycle after its ack is treated as a new request and competes normally.
- mem_address, mem_page, mem_to_mem and mem_wren stay constant from ISSUE through DONE and keep their values while in IDLE.
- mem_ready pulses that arrive outside WAIT are ignored. This includes a late ready after a timeout.
- Requests that are dropped before being granted are lost silently. Dropping a request after grant is illegal, and the transaction completes anyway.

## Timing
- Reset values:
  - State: IDLE.
  - last_grant=2, so client 0 has priority first.
  - mem_req, mem_wren, all cN_ack, all cN_err, timeout_flag: 0.
  - mem_address, mem_page, mem_to_mem, c_rdata: 0.
- rst mid-transaction abandons the transaction immediately. No ack is produced, and the next cycle is IDLE with the reset values.
- Request to mem_req: cN_req is sampled high in IDLE at cycle t, and mem_req=1 at t+1.
- mem_ready to ack: mem_ready is sampled at cycle r, and cN_ack=1 at r+1. c_rdata is valid from r+1 and is held until the next successful read.
- Minimum spacing between mem_req pulses is 3 low cycles (WAIT, DONE, IDLE). This satisfies the controller's rising-edge detection.
- Abort timing: ack occurs TIMEOUT_CYCLES+1 cycles after the ISSUE cycle.
- Throughput is one transaction per (controller latency + 3) cycles. Fairness: each active client is granted at least once every 3 grants.

## Test plan
- Single read: c1 reads addr 0x12345, the controller model returns 0xDEADBEEF_01234567 with mem_ready 9 cycles after mem_req. Required: mem_page=0x09, mem_address=0x0345, mem_wren=0. c1_ack at 10 cycles after mem_req, with c_rdata equal to the returned data and c1_err=0.
- Write: c2 writes 0xA5A5... to 0x00003. Required: one mem_req pulse with mem_wren=1 and mem_to_mem=0xA5A5...; c2_ack follows mem_ready by 1 cycle; c_rdata is unchanged.
- Round robin: c0, c1 and c2 all hold req continuously after reset. Required: grant order 0,1,2,0,1,2 and exactly one mem_req per ack.
- Timeout: TIMEOUT_CYCLES=16 and the model never asserts ready. Required: c0_ack with c0_err=1 exactly 17 cycles after ISSUE, timeout_flag=1. A later mem_ready pulse in IDLE is ignored.
- Collision: mem_ready arrives in the same cycle the watchdog reaches 0. Required: normal completion with err=0 and timeout_flag unchanged.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT. Required: no ack, all outputs at reset values, and the next request is serviced normally.
